// File: rtl/td100_pkg.sv
// ---------------------------------------------------------------------------
// td100_pkg
//   Shared definitions for the TD100 delay-line monitor.
//   - td100State_e : monitor FSM states
//   - TD100_NTAPS  : default number of delay-line taps
//   - TD100_CNT_W  : default width of the cycle counter and of each delay field
//   - getDelay()   : pulls one tap's delay field out of the packed delay bus
// ---------------------------------------------------------------------------
package td100_pkg;

    localparam int TD100_NTAPS = 5;
    localparam int TD100_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } td100State_e;

    // Tap i sits at bits [i*CNT_W +: CNT_W] of the packed delay bus.
    function automatic logic [TD100_CNT_W-1:0] getDelay(
        input logic [TD100_NTAPS*TD100_CNT_W-1:0] delayBus,
        input int unsigned                        tapIdx
    );
        return delayBus[tapIdx*TD100_CNT_W +: TD100_CNT_W];
    endfunction

endpackage

// File: rtl/td100_sync_edge.sv
// ---------------------------------------------------------------------------
// td100_sync_edge
//   Two-flop synchronizer for one asynchronous input, followed by a history
//   register that turns the synchronized level into a one-cycle edge pulse.
//   The RISING parameter picks the edge: 1 = rising, 0 = falling.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     async_i  in   asynchronous input level
//     edge_o   out  one-cycle pulse on the selected edge of the synced level
// ---------------------------------------------------------------------------
module td100_sync_edge #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic edge_o
);

    logic syncMeta_q;
    logic syncStable_q;
    logic history_q;

    // The first flop may go metastable; the second gives a clean level and
    // the third remembers last cycle's level for edge detection. All three
    // reset low, so an input that idles high (tap_n) cannot fake a falling
    // edge as it propagates in after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta_q   <= 1'b0;
            syncStable_q <= 1'b0;
            history_q    <= 1'b0;
        end else begin
            syncMeta_q   <= async_i;
            syncStable_q <= syncMeta_q;
            history_q    <= syncStable_q;
        end
    end

    assign edge_o = RISING ? (syncStable_q & ~history_q)
                           : (~syncStable_q & history_q);

endmodule

// File: rtl/td100_monitor.sv
// ---------------------------------------------------------------------------
// td100_monitor
//   Synchronous receiver for a TD100-style five-tap delay line. After an arm
//   request it waits for the rising edge of the line input, then
//   timestamps the first active-low pulse on each tap in clock cycles. It
//   flags taps that fire out of order and measurements that time out. It
//   holds the results until the host acknowledges them.
//
//   Optional feature: define TD100_MON_WINDOW_EN to enable the per-tap
//   window check. Tap i is then expected at (i+1)*EXP_STEP +/- TOL cycles.
//   Without the macro, window_err stays 0.
//
//   Ports:
//     clk         in   system clock
//     reset_n     in   asynchronous active-low reset
//     start       in   delay-line input (async); rising edge starts a run
//     tap_n       in   tap outputs (async), active-low pulses
//     arm         in   one-cycle arm request, honoured in IDLE only
//     ack         in   one-cycle result release, honoured in DONE only
//     busy        out  high while ARMED or MEASURE
//     done        out  high while DONE
//     delay       out  per-tap latched count, tap i at [i*CNT_W +: CNT_W]
//     tap_seen    out  per-tap "edge captured" flag
//     timeout     out  the run ended on the TIMEOUT count
//     order_err   out  a tap fired after a higher-index tap
//     window_err  out  per-tap window violation
// ---------------------------------------------------------------------------
module td100_monitor
    import td100_pkg::*;
#(
    parameter int NTAPS    = TD100_NTAPS,
    parameter int CNT_W    = TD100_CNT_W,
    parameter int TIMEOUT  = 255,
    parameter int EXP_STEP = 2,
    parameter int TOL      = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [NTAPS-1:0]       tap_n,
    input  logic                   arm,
    input  logic                   ack,
    output logic                   busy,
    output logic                   done,
    output logic [NTAPS*CNT_W-1:0] delay,
    output logic [NTAPS-1:0]       tap_seen,
    output logic                   timeout,
    output logic                   order_err,
    output logic [NTAPS-1:0]       window_err
);

`ifdef TD100_MON_WINDOW_EN
    localparam bit WindowEn = 1'b1;
`else
    localparam bit WindowEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    td100State_e                 state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [NTAPS-1:0][CNT_W-1:0] delay_q, delay_d;
    logic [NTAPS-1:0]            seen_q, seen_d;
    logic                        timeout_q, timeout_d;
    logic                        orderErr_q, orderErr_d;
    logic [NTAPS-1:0]            winErr_q, winErr_d;

    logic                        startEdge;
    logic [NTAPS-1:0]            tapEdge;
    logic [NTAPS-1:0]            newCap;
    logic [NTAPS-1:0]            seenNow;

    // Start and every tap go through identical synchronizers, so their
    // latency is the same and cancels out of the measured delay.
    td100_sync_edge #(.RISING(1'b1)) u_startSync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (start),
        .edge_o  (startEdge)
    );

    for (genvar t = 0; t < NTAPS; t++) begin : g_tapSync
        td100_sync_edge #(.RISING(1'b0)) u_tapSync (
            .clk     (clk),
            .reset_n (reset_n),
            .async_i (tap_n[t]),
            .edge_o  (tapEdge[t])
        );
    end

    // True when a delay of cnt lies outside the window expected for tap
    // tapIdx.
    function automatic logic outOfWindow(input int tapIdx, input logic [CNT_W-1:0] cnt);
        int expect_d;
        expect_d = (tapIdx + 1) * EXP_STEP;
        return (int'(cnt) < expect_d - TOL) || (int'(cnt) > expect_d + TOL);
    endfunction

    // Next-state and result logic. The counter reads 0 during the cycle
    // in which the start edge is seen, so a tap edge seen k cycles later
    // reads k. A capture in the cycle the count hits TIMEOUT still counts.
    // Only taps already captured in an earlier cycle (seen_q) can cause an
    // ordering error.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        delay_d    = delay_q;
        seen_d     = seen_q;
        timeout_d  = timeout_q;
        orderErr_d = orderErr_q;
        winErr_d   = winErr_q;
        newCap     = '0;
        seenNow    = seen_q;

        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d    = ARMED;
                    count_d    = '0;
                    delay_d    = '0;
                    seen_d     = '0;
                    timeout_d  = 1'b0;
                    orderErr_d = 1'b0;
                    winErr_d   = '0;
                end
            end

            ARMED: begin
                if (startEdge) begin
                    state_d = MEASURE;
                    count_d = CNT_W'(1);
                end
            end

            MEASURE: begin
                newCap  = tapEdge & ~seen_q;
                seenNow = seen_q | newCap;
                for (int i = 0; i < NTAPS; i++) begin
                    if (newCap[i]) begin
                        delay_d[i] = count_q;
                        for (int j = i + 1; j < NTAPS; j++) begin
                            if (seen_q[j]) begin
                                orderErr_d = 1'b1;
                            end
                        end
                        if (WindowEn && outOfWindow(i, count_q)) begin
                            winErr_d[i] = 1'b1;
                        end
                    end
                end
                seen_d = seenNow;

                if (&seenNow) begin
                    state_d = DONE;
                end else if (count_q == TimeoutCnt) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    if (WindowEn) begin
                        winErr_d = winErr_d | ~seenNow;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers. Reset returns to IDLE and clears
    // everything at once, even in the middle of a measurement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            delay_q    <= '0;
            seen_q     <= '0;
            timeout_q  <= 1'b0;
            orderErr_q <= 1'b0;
            winErr_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            delay_q    <= delay_d;
            seen_q     <= seen_d;
            timeout_q  <= timeout_d;
            orderErr_q <= orderErr_d;
            winErr_q   <= winErr_d;
        end
    end

    assign busy       = (state_q == ARMED) || (state_q == MEASURE);
    assign done       = (state_q == DONE);
    assign delay      = delay_q;
    assign tap_seen   = seen_q;
    assign timeout    = timeout_q;
    assign order_err  = orderErr_q;
    assign window_err = winErr_q;

endmodule

// File: tb/tb_td100_monitor.sv
// ---------------------------------------------------------------------------
// tb_td100_monitor
//   Self-checking bench for td100_monitor. Each run's expected result is
//   derived from the tap arrival times and pushed into a scoreboard queue.
//   A monitor pops and compares it when done rises. Directed runs cover the
//   nominal sequence, ordering, timeout, simultaneous and ignored events,
//   mid-run reset and the window case; random runs follow.
//   Window expectations follow TD100_MON_WINDOW_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_td100_monitor;
    import td100_pkg::*;

    localparam int NTAPS    = 5;
    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 255;
    localparam int EXP_STEP = 2;
    localparam int TOL      = 1;

    typedef struct packed {
        logic [NTAPS-1:0][CNT_W-1:0] delay;
        logic [NTAPS-1:0]            seen;
        logic                        timeout;
        logic                        orderErr;
        logic [NTAPS-1:0]            winErr;
        logic [15:0]                 id;
    } expT;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   start;
    logic [NTAPS-1:0]       tap_n;
    logic                   arm;
    logic                   ack;
    logic                   busy;
    logic                   done;
    logic [NTAPS*CNT_W-1:0] delay;
    logic [NTAPS-1:0]       tap_seen;
    logic                   timeout;
    logic                   order_err;
    logic [NTAPS-1:0]       window_err;

    int  errors = 0;
    int  checks = 0;
    expT sbQ[$];
    bit  doneSeen = 1'b0;

    int  firstK[NTAPS];
    int  extraK[NTAPS];
    int  restartK;
    int  resetK;
    int  ignoredK;
    int  runId = 0;

    always #5 clk = ~clk;

    td100_monitor #(
        .NTAPS    (NTAPS),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .EXP_STEP (EXP_STEP),
        .TOL      (TOL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .tap_n      (tap_n),
        .arm        (arm),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .delay      (delay),
        .tap_seen   (tap_seen),
        .timeout    (timeout),
        .order_err  (order_err),
        .window_err (window_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"},      busy,       0);
        checkOutput({tag, ".done"},      done,       0);
        checkOutput({tag, ".delay"},     delay,      0);
        checkOutput({tag, ".tapSeen"},   tap_seen,   0);
        checkOutput({tag, ".timeout"},   timeout,    0);
        checkOutput({tag, ".orderErr"},  order_err,  0);
        checkOutput({tag, ".windowErr"}, window_err, 0);
    endtask

    // Expected result from first-arrival times: the run ends when every tap
    // has arrived or at count TIMEOUT. Taps arriving by then report their
    // arrival cycle as delay.
    task automatic pushExpected();
        expT e;
        bit  allIn;
        int  expect_d;
        e     = '0;
        e.id  = 16'(runId);
        allIn = 1'b1;
        for (int i = 0; i < NTAPS; i++) begin
            if (firstK[i] < 1 || firstK[i] > TIMEOUT) allIn = 1'b0;
        end
        e.timeout = !allIn;
        for (int i = 0; i < NTAPS; i++) begin
            if (firstK[i] >= 1 && firstK[i] <= TIMEOUT) begin
                e.seen[i]  = 1'b1;
                e.delay[i] = CNT_W'(firstK[i]);
            end
        end
        for (int i = 0; i < NTAPS; i++) begin
            for (int j = i + 1; j < NTAPS; j++) begin
                if (e.seen[i] && e.seen[j] && firstK[j] < firstK[i]) e.orderErr = 1'b1;
            end
        end
`ifdef TD100_MON_WINDOW_EN
        for (int i = 0; i < NTAPS; i++) begin
            expect_d = (i + 1) * EXP_STEP;
            if (e.seen[i]) begin
                if (firstK[i] < expect_d - TOL || firstK[i] > expect_d + TOL) e.winErr[i] = 1'b1;
            end else if (e.timeout) begin
                e.winErr[i] = 1'b1;
            end
        end
`else
        expect_d = 0;
`endif
        sbQ.push_back(e);
    endtask

    // Scoreboard monitor: one comparison set per rising edge of done.
    always @(negedge clk) begin
        expT e;
        if (done && !doneSeen) begin
            doneSeen = 1'b1;
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedDone", 1, 0);
            end else begin
                e = sbQ.pop_front();
                for (int i = 0; i < NTAPS; i++) begin
                    checkOutput($sformatf("run%0d.delay%0d", e.id, i), getDelay(delay, i), e.delay[i]);
                end
                checkOutput($sformatf("run%0d.tapSeen", e.id),   tap_seen,   e.seen);
                checkOutput($sformatf("run%0d.timeout", e.id),   timeout,    e.timeout);
                checkOutput($sformatf("run%0d.orderErr", e.id),  order_err,  e.orderErr);
                checkOutput($sformatf("run%0d.windowErr", e.id), window_err, e.winErr);
                checkOutput($sformatf("run%0d.busyWithDone", e.id), busy, 0);
            end
        end
        if (!done) doneSeen = 1'b0;
    end

    // One measurement: arm, raise start at cycle 0, pulse taps at their
    // scheduled cycles, optionally inject ignored events or a reset, and
    // acknowledge when done appears.
    task automatic applyStimulus();
        bit ended;
        bit sawDone;
        runId++;
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("run%0d.busyAfterArm", runId), busy, 1);
        checkOutput($sformatf("run%0d.seenClearedOnArm", runId), tap_seen, 0);
        if (resetK < 0) pushExpected();

        ended   = 1'b0;
        sawDone = 1'b0;
        for (int n = 0; n <= TIMEOUT + 40 && !ended; n++) begin
            @(posedge clk); #1;
            sawDone = done;
            if (sawDone) begin
                ended = 1'b1;
            end else begin
                start = !(restartK >= 0 && n == restartK);
                for (int i = 0; i < NTAPS; i++) begin
                    tap_n[i] = !(n == firstK[i] || n == extraK[i]);
                end
                arm = (n == ignoredK);
                ack = (n == ignoredK);
                if (resetK >= 0 && n == resetK) begin
                    reset_n = 1'b0;
                    ended   = 1'b1;
                end
            end
        end
        arm   = 1'b0;
        ack   = 1'b0;
        tap_n = '1;

        if (resetK >= 0) begin
            @(negedge clk);
            checkAllZero($sformatf("run%0d.afterReset", runId));
            @(posedge clk); #1;
            start   = 1'b0;
            reset_n = 1'b1;
        end else begin
            checkOutput($sformatf("run%0d.doneWithinBound", runId), sawDone, 1);
            @(posedge clk); #1 ack = 1'b1; start = 1'b0;
            @(posedge clk); #1 ack = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("run%0d.idleAfterAck", runId), {busy, done}, 0);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic setNominal();
        for (int i = 0; i < NTAPS; i++) begin
            firstK[i] = (i + 1) * 2;
            extraK[i] = -1;
        end
        restartK = -1;
        resetK   = -1;
        ignoredK = -1;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        tap_n   = '1;
        arm     = 1'b0;
        ack     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);

        setNominal();
        applyStimulus();

        setNominal();
        firstK[3] = 6;
        firstK[2] = 8;
        applyStimulus();

        setNominal();
        firstK[4] = -1;
        applyStimulus();

        setNominal();
        firstK[0] = 5;
        firstK[1] = 5;
        extraK[0] = 8;
        restartK  = 7;
        ignoredK  = 6;
        applyStimulus();

        setNominal();
        resetK = 7;
        applyStimulus();
        setNominal();
        applyStimulus();

        setNominal();
        firstK[2] = 9;
        applyStimulus();

        for (int r = 0; r < 25; r++) begin
            setNominal();
            for (int i = 0; i < NTAPS; i++) begin
                firstK[i] = (i + 1) * EXP_STEP + int'($urandom_range(0, 4)) - 2;
                if (firstK[i] < 1) firstK[i] = 1;
                if ($urandom_range(0, 11) == 0) firstK[i] = -1;
                if (firstK[i] > 0 && $urandom_range(0, 1) == 1) begin
                    extraK[i] = firstK[i] + int'($urandom_range(2, 6));
                end
            end
            if ($urandom_range(0, 3) == 0) restartK = int'($urandom_range(4, 12));
            if ($urandom_range(0, 3) == 0) ignoredK = int'($urandom_range(0, 12));
            applyStimulus();
        end

        checkOutput("scoreboardDrained", sbQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
